// File: rtl/narnet_pkg.sv
// Shared types and constants for the NARNet job sequencer.
package narnet_pkg;

  localparam int unsigned N_DEFAULT          = 8;
  localparam int unsigned Q_DEFAULT          = 7;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  // Value the core loads into its tap-delay line on core_rst: 0.375 = 3/8.
  localparam logic [N_DEFAULT-1:0] DELAY_INIT = N_DEFAULT'(3 << (Q_DEFAULT - 3));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_ISSUE,
    S_WAIT,
    S_STORE
  } seq_state_e;

endpackage

// File: rtl/narnet_seq_if.sv
// Priming-sample input stream and forecast output stream of the sequencer.
interface narnet_seq_if
  import narnet_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) ();

  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/narnet_seq_fifo.sv
// Synchronous forecast buffer (data + last flag); DEPTH must be a power of two.
module narnet_seq_fifo
  import narnet_pkg::*;
#(
  parameter int unsigned W     = N_DEFAULT,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_last,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_last,
  output logic         empty,
  output logic         free
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign free  = !full;
  assign do_rd = rd_en && !empty;
  // A simultaneous read frees the slot the write lands in.
  assign do_wr = wr_en && (!full || do_rd);

  assign {rd_last, rd_data} = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/narnet_seq.sv
// NARNet job sequencer: primes the core open-loop, then feeds predictions back.
// Optional core watchdog enabled by defining NARNET_SEQ_TIMEOUT_EN.
module narnet_seq
  import narnet_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned Q          = Q_DEFAULT,
  parameter int unsigned CW         = 8,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_prime,
  input  logic [CW-1:0] cfg_horizon,
  output logic          busy,
  output logic          done,
  output logic          err,
  narnet_seq_if.slave   strm,
  output logic          core_en,
  output logic          core_rst,
  output logic [N-1:0]  core_x_in,
  output logic          core_x_ready,
  input  logic [N-1:0]  core_y_out,
  input  logic          core_out_ready
);

  seq_state_e    state;
  logic [CW-1:0] p_q;
  logic [CW-1:0] h_q;
  logic [CW-1:0] fed;
  logic [CW-1:0] wr_cnt;
  logic [N-1:0]  y_q;
  logic          priming;
  logic          fifo_wr;
  logic          fifo_last;
  logic          fifo_empty;
  logic          fifo_free;

  assign priming   = (fed < p_q);
  assign fifo_wr   = (state == S_STORE) && !priming;
  assign fifo_last = (wr_cnt == h_q - 1'b1);

`ifdef NARNET_SEQ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      strm.in_ready <= 1'b0;
      core_x_ready <= 1'b0;
      core_x_in    <= '0;
      core_rst     <= 1'b1;
      core_en      <= 1'b0;
      p_q          <= '0;
      h_q          <= '0;
      fed          <= '0;
      wr_cnt       <= '0;
      y_q          <= '0;
`ifdef NARNET_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      core_en      <= 1'b1;
      core_rst     <= 1'b0;
      core_x_ready <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            p_q      <= (cfg_prime == '0) ? CW'(1) : cfg_prime;
            h_q      <= (cfg_horizon == '0) ? CW'(1) : cfg_horizon;
            fed      <= '0;
            wr_cnt   <= '0;
            busy     <= 1'b1;
            core_rst <= 1'b1;
            state    <= S_CRST;
`ifdef NARNET_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        S_CRST: begin
          strm.in_ready <= fifo_free;
          state         <= S_ISSUE;
        end
        // in_ready is registered; the slot it advertises cannot be taken
        // while in ISSUE because only STORE writes the buffer.
        S_ISSUE: begin
          if (priming) begin
            if (strm.in_ready && strm.in_valid) begin
              strm.in_ready <= 1'b0;
              core_x_in     <= strm.in_data;
              core_x_ready  <= 1'b1;
              fed           <= fed + 1'b1;
              state         <= S_WAIT;
            end else begin
              strm.in_ready <= fifo_free;
            end
          end else if (fifo_free) begin
            core_x_in    <= y_q;
            core_x_ready <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef NARNET_SEQ_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
          if (core_out_ready) begin
            y_q   <= core_y_out;
            state <= S_STORE;
`ifdef NARNET_SEQ_TIMEOUT_EN
            wd_cnt <= '0;
          end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            wd_cnt   <= '0;
            state    <= S_IDLE;
`endif
          end
        end
        S_STORE: begin
          if (priming) begin
            strm.in_ready <= fifo_free;
            state         <= S_ISSUE;
          end else if (fifo_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
            state  <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  narnet_seq_fifo #(
    .W     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (y_q),
    .wr_last (fifo_last),
    .rd_en   (strm.out_ready),
    .rd_data (strm.out_data),
    .rd_last (strm.out_last),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  assign strm.out_valid = !fifo_empty;

endmodule

// File: tb/tb_narnet_seq.sv
// Bench for narnet_seq with a stub core (y = x + 1, answer 20 cycles after each strobe).
module tb_narnet_seq;
  import narnet_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_prime;
  logic [CW-1:0] cfg_horizon;
  logic          busy, done, err;
  logic          core_en, core_rst, core_x_ready;
  logic [N-1:0]  core_x_in;
  logic [N-1:0]  core_y_out = '0;
  logic          core_out_ready = 1'b0;

  narnet_seq_if #(.N(N)) strm ();

  narnet_seq #(
    .N(N), .Q(7), .CW(CW), .FIFO_DEPTH(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_prime(cfg_prime), .cfg_horizon(cfg_horizon),
    .busy(busy), .done(done), .err(err),
    .strm(strm),
    .core_en(core_en), .core_rst(core_rst),
    .core_x_in(core_x_in), .core_x_ready(core_x_ready),
    .core_y_out(core_y_out), .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  // Stub core
  int unsigned  stub_cnt = 0;
  logic [N-1:0] stub_x = '0;
  bit           stub_on = 1'b1;
  always @(posedge clk) begin
    core_out_ready <= 1'b0;
    if (rst || core_rst) stub_cnt <= 0;
    else if (core_x_ready) begin
      stub_cnt <= 20;
      stub_x   <= core_x_in;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_on) begin
        core_out_ready <= 1'b1;
        core_y_out     <= stub_x + 1'b1;
      end
    end
  end

  // Observers
  logic [N:0]   got_q[$];
  logic [N-1:0] xs_q[$];
  int           done_cnt = 0, crst_cnt = 0, dbl_cnt = 0;
  logic         prev_xr = 1'b0, prev_crst = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (strm.out_valid && strm.out_ready) got_q.push_back({strm.out_last, strm.out_data});
      if (core_x_ready) xs_q.push_back(core_x_in);
      if (core_x_ready && prev_xr) dbl_cnt++;
      if (done) done_cnt++;
      if (core_rst && !prev_crst) crst_cnt++;
    end
    prev_xr   = core_x_ready;
    prev_crst = core_rst;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string t, input string s, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s_%s: observed 'h%0h, expected 'h%0h", t, s, obs, exp);
    end
  endtask

  logic [N-1:0] src[$];
  int           src_idx;
  bit           rand_ready = 1'b0;
  logic [N:0]   exp_out[$];
  logic [N-1:0] exp_x[$];

  // Reference: strobes are the P inputs then every forecast but the last;
  // forecasts count up by one from the last priming sample.
  function automatic void build_model(input int p, input int h);
    int pp, hh;
    logic [N-1:0] f;
    pp = (p == 0) ? 1 : p;
    hh = (h == 0) ? 1 : h;
    exp_out.delete();
    exp_x.delete();
    for (int i = 0; i < pp; i++) exp_x.push_back(src[i]);
    f = src[pp-1] + 1'b1;
    for (int k = 0; k < hh; k++) begin
      exp_out.push_back({(k == hh - 1), f});
      if (k < hh - 1) exp_x.push_back(f);
      f = f + 1'b1;
    end
  endfunction

  task automatic tick();
    bit hs;
    @(negedge clk);
    hs = strm.in_valid && strm.in_ready;
    @(posedge clk);
    #1;
    if (hs) src_idx++;
    strm.in_valid = (src_idx < src.size());
    strm.in_data  = (src_idx < src.size()) ? src[src_idx] : '0;
    if (rand_ready) strm.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start(input int p, input int h);
    cfg_prime   = CW'(p);
    cfg_horizon = CW'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_src(input int pp);
    src.delete();
    for (int i = 0; i < pp; i++) src.push_back(N'($urandom_range(0, 255)));
    src_idx = 0;
    strm.in_valid = 1'b1;
    strm.in_data  = src[0];
    got_q.delete();
    xs_q.delete();
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, "done", done_cnt, target);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rand_ready = 1'b0;
    strm.out_ready = 1'b1;
    while (strm.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, "drained", strm.out_valid, 1'b0);
  endtask

  task automatic check_job(input string tag);
    chk(tag, "n_out", got_q.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < got_q.size(); i++)
      chk(tag, "out", got_q[i], exp_out[i]);
    chk(tag, "n_strobe", xs_q.size(), exp_x.size());
    for (int i = 0; i < exp_x.size() && i < xs_q.size(); i++)
      chk(tag, "strobe", xs_q[i], exp_x[i]);
    got_q.delete();
    xs_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk(tag, "busy", busy, 1'b0);
    chk(tag, "done", done, 1'b0);
    chk(tag, "err", err, 1'b0);
    chk(tag, "in_ready", strm.in_ready, 1'b0);
    chk(tag, "out_valid", strm.out_valid, 1'b0);
    chk(tag, "out_last", strm.out_last, 1'b0);
    chk(tag, "out_data", strm.out_data, 8'h00);
    chk(tag, "core_x_ready", core_x_ready, 1'b0);
    chk(tag, "core_x_in", core_x_in, 8'h00);
    chk(tag, "core_rst", core_rst, 1'b1);
    chk(tag, "core_en", core_en, 1'b0);
  endtask

  task automatic job(input int p, input int h, input bit preset, input bit rnd, input string tag);
    int d0, c0;
    if (!preset) load_src((p == 0) ? 1 : p);
    else begin
      src_idx = 0;
      strm.in_valid = 1'b1;
      strm.in_data  = src[0];
      got_q.delete();
      xs_q.delete();
    end
    build_model(p, h);
    d0 = done_cnt;
    c0 = crst_cnt;
    rand_ready = rnd;
    strm.out_ready = 1'b1;
    pulse_start(p, h);
    chk(tag, "start_core_rst", core_rst, 1'b1);
    chk(tag, "start_busy", busy, 1'b1);
    chk(tag, "start_err", err, 1'b0);
    tick();
    chk(tag, "crst_width", core_rst, 1'b0);
    chk(tag, "first_in_ready", strm.in_ready, 1'b1);
    wait_done(d0 + 1, tag);
    drain(tag);
    check_job(tag);
    chk(tag, "crst_pulses", crst_cnt - c0, 1);
    chk(tag, "end_busy", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0, c0, n;
    rst = 1'b1;
    start = 1'b0;
    cfg_prime = '0;
    cfg_horizon = '0;
    strm.in_valid = 1'b0;
    strm.in_data = '0;
    strm.out_ready = 1'b0;
    src_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    tick();
    n_assert++;
    if (core_en !== 1'b1) begin
      n_fail++;
      $error("FAIL reset_release_core_en: observed 'h%0h, expected 'h1", core_en);
    end
    n_assert++;
    if (core_rst !== 1'b0) begin
      n_fail++;
      $error("FAIL reset_release_core_rst: observed 'h%0h, expected 'h0", core_rst);
    end

    // Directed: P=3, H=3
    src.delete();
    src.push_back(8'h10);
    src.push_back(8'h20);
    src.push_back(8'h30);
    job(3, 3, 1'b1, 1'b0, "p3h3");

    // Zero counts behave as one
    job(0, 0, 1'b0, 1'b0, "p0h0");

    // Random jobs with random sink back-pressure
    for (int i = 0; i < 4; i++)
      job($urandom_range(1, 5), $urandom_range(1, 6), 1'b0, 1'b1, "rand");

    // Sink stalled: buffer fills, issue stops, nothing is lost
    load_src(1);
    build_model(1, 8);
    rand_ready = 1'b0;
    strm.out_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(1, 8);
    repeat (300) tick();
    n_assert++;
    if (xs_q.size() !== 4) begin
      n_fail++;
      $error("FAIL stall_n_strobe: observed 'h%0h, expected 'h4", xs_q.size());
    end
    n_assert++;
    if (got_q.size() !== 0) begin
      n_fail++;
      $error("FAIL stall_n_out: observed 'h%0h, expected 'h0", got_q.size());
    end
    n_assert++;
    if (strm.out_valid !== 1'b1) begin
      n_fail++;
      $error("FAIL stall_out_valid: observed 'h%0h, expected 'h1", strm.out_valid);
    end
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $error("FAIL stall_busy: observed 'h%0h, expected 'h1", busy);
    end
    strm.out_ready = 1'b1;
    wait_done(d0 + 1, "stall");
    drain("stall");
    check_job("stall");

    // start while busy is ignored
    load_src(2);
    build_model(2, 2);
    d0 = done_cnt;
    c0 = crst_cnt;
    pulse_start(2, 2);
    repeat (5) tick();
    cfg_prime = 8'd5;
    cfg_horizon = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, "busy_start");
    drain("busy_start");
    check_job("busy_start");
    chk("busy_start", "crst_pulses", crst_cnt - c0, 1);

    // rst during WAIT with buffered data
    load_src(1);
    strm.out_ready = 1'b0;
    pulse_start(1, 3);
    n = 0;
    while (xs_q.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    chk("mid_rst", "n_strobe", xs_q.size(), 3);
    repeat (3) tick();
    chk("mid_rst", "pre_out_valid", strm.out_valid, 1'b1);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    strm.in_valid = 1'b0;
    strm.out_ready = 1'b1;
    tick();
    got_q.delete();
    xs_q.delete();

`ifdef NARNET_SEQ_TIMEOUT_EN
    // Core never answers: watchdog fires after 255 WAIT cycles
    load_src(1);
    stub_on = 1'b0;
    d0 = done_cnt;
    pulse_start(1, 1);
    n = 0;
    while (!core_x_ready && n < 50) begin
      tick();
      n++;
    end
    chk("timeout", "strobe_seen", core_x_ready, 1'b1);
    n = 0;
    while (!err && n < 400) begin
      tick();
      n++;
    end
    chk("timeout", "wait_cycles", n, 255);
    chk("timeout", "err", err, 1'b1);
    chk("timeout", "core_rst", core_rst, 1'b1);
    chk("timeout", "busy", busy, 1'b0);
    tick();
    chk("timeout", "no_done", done_cnt, d0);
    chk("timeout", "err_sticky", err, 1'b1);
    stub_on = 1'b1;
    job(1, 2, 1'b0, 1'b0, "after_timeout");
`endif

    n_assert++;
    if (dbl_cnt !== 0) begin
      n_fail++;
      $error("FAIL global_double_strobe: observed 'h%0h, expected 'h0", dbl_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/narnet_seq.md
# narnet_seq

Job sequencer for the NARNet inference core.
- Resets the core's tap-delay line at the start of each job.
- Streams P priming samples into the core open-loop, then runs closed-loop forecasting: each core prediction is fed back as the next input until H forecast values exist.
- Forecasts leave through a small buffered valid/ready stream.
- Sits between the sample source/result sink and the core's `x_ready`/`out_ready` pulse interface.

## Interface
- N, 8, sample width (signed fixed point)
- Q, 7, fractional bits (pass-through to package constants only)
- CW, 8, width of prime/horizon counts
- FIFO_DEPTH, 4, output buffer entries (power of two)
- TIMEOUT, 255, core watchdog limit in cycles (used only with NARNET_SEQ_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request pulse; ignored while busy
- cfg_prime  in  CW  priming sample count P, sampled on start; 0 treated as 1
- cfg_horizon  in  CW  forecast count H, sampled on start; 0 treated as 1
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the last forecast is written to the FIFO
- err  out  1  sticky watchdog error; cleared on start
- in_valid / in_data / in_ready  in/in/out  1/N/1  priming sample stream
- out_valid / out_data / out_last / out_ready  out/out/out/in  1/N/1/1  forecast stream
- core_en  out  1  core enable
- core_rst  out  1  core reset
- core_x_in  out  N  core input sample
- core_x_ready  out  1  one-cycle input strobe to core
- core_y_out  in  N  core prediction
- core_out_ready  in  1  one-cycle result strobe from core

## Operation
States: IDLE, CRST, ISSUE, WAIT, STORE.
- IDLE: on start, latch P and H (0→1), clear err, set busy, go to CRST.
- CRST: core_rst=1 for exactly one cycle (delay line reinitialised to 0.375), then go to ISSUE.
- ISSUE, prime phase (fed<P): in_ready=1 only if the FIFO has ≥1 free slot. On handshake, register in_data into core_x_in, pulse core_x_ready next cycle, go to WAIT.
- ISSUE, forecast phase: requires a free FIFO slot. core_x_in = last core_y_out, pulse core_x_ready, go to WAIT. No in_ready.
- WAIT: hold until core_out_ready, capture core_y_out, go to STORE.
- STORE, prime runs 1..P-1: discard the result, return to ISSUE.
- STORE, prime run P and every closed-loop run: write the result to the FIFO.
  - out_last=1 on the H-th write, with a done pulse, busy=0, then IDLE.
  - Otherwise return to ISSUE (forecast phase).
- One core transaction in flight at most. A slot is checked before issue, so FIFO overflow is impossible.
- core_en=1 whenever not in reset.
- Feedback uses the core output unmodified; the core already saturates.
- FIFO empty: out_valid=0. The FIFO drains normally after done; a new start is allowed while it is non-empty.
- out_ready low indefinitely stalls issue once the FIFO is full; no data is lost.

## Timing
- Reset values: busy=0, done=0, err=0, in_ready=0, out_valid=0, out_last=0, out_data=0, core_x_ready=0, core_x_in=0, core_rst=1 (core reset while rst), core_en=0.
- rst mid-job: abort immediately, flush the FIFO, all outputs go to reset values next cycle.
- start to core_rst: 1 cycle. core_rst to first in_ready: 1 cycle.
- in handshake to core_x_ready: 1 cycle.
- core_out_ready to FIFO write: 1 cycle (STORE). FIFO write to out_valid: 1 cycle.
- FIFO read and write in the same cycle while full: both proceed; occupancy is unchanged.
- core_x_ready is never high on two consecutive cycles.

## Configuration
- NARNET_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - At TIMEOUT cycles without core_out_ready: set err, pulse core_rst one cycle, clear busy, go to IDLE without done.
  - FIFO contents are kept.
- Undefined: no counter, err tied 0, WAIT waits forever.

## Structure
- narnet_pkg holds:
  - state enum
  - default N/Q
  - DELAY_INIT constant (0.375 in the current Q format)
  - FIFO depth default
- One sub-module: narnet_seq_fifo, synchronous FIFO with full/empty/free flags. Data plus last bit, depth FIFO_DEPTH.

## Test plan
All cases use a stub core: core_y_out = core_x_in+1, core_out_ready 20 cycles after core_x_ready.
- P=3, H=3, inputs 0x10,0x20,0x30, out_ready=1 → outputs 0x31,0x32,0x33; out_last only on 0x33; one done pulse; exactly one core_rst pulse after start.
- P=0, H=0 → treated as 1/1: one input consumed, one output (input+1) with out_last and done.
- P=1, H=8, out_ready=0 → 4 outputs buffered, then no further core_x_ready. Raise out_ready → 0x..+1..+8 delivered in order, no loss.
- start pulsed while busy → ignored, latched P/H unchanged. rst during WAIT → all outputs at reset values next cycle, FIFO empty.
- With NARNET_SEQ_TIMEOUT_EN, stub never answers → err=1 after 255 WAIT cycles, core_rst pulse, busy=0, no done. Next start clears err.
- Forecast phase: core_x_in equals the previous core_y_out on every feedback strobe.
